t02_ram_responder: RTL and testbench

Memory-side responder for the CPU request unit's RAM bus. It accepts single-word read and write requests (`read_i`, `write_i`, `adr_i`, `cpu_data_i`, `sel_i`) and holds `busy_o` high for a fixed latency. It then commits the write with byte-lane masking, or returns the read word on `cpu_dat_o`. Storage is an internal word array, so the core and FPGA module can run against it in simulation and on the FPGA.

---
 rtl/t02_ram_pkg.sv | 26 ++
 rtl/t02_ram_bytearray.sv | 38 +++
 rtl/t02_ram_responder.sv | 119 +++++++++++
 tb/tb_t02_ram_responder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/t02_ram_pkg.sv
// Shared types and constants for the t02 RAM responder.
// Holds the FSM state encoding, the captured request layout and the address range helper.
package t02_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ram_state_t;

  typedef struct packed {
    logic        is_write;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } ram_req_t;

  localparam int unsigned T02_RAM_DEFAULT_LATENCY = 2;
  localparam logic [31:0] T02_RAM_OOR_READ_VALUE  = 32'h0000_0000;

  // A byte address is in range when every bit above the word index is zero.
  function automatic logic addr_in_range(input logic [31:0] adr, input int unsigned aw);
    return (adr >> (aw + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/t02_ram_bytearray.sv
// Single-port 2^ADDR_WIDTH x 32 word store with per-byte write enables.
// Latency: write commits and read data registers on the enabling edge.
// Backpressure: none; the owning FSM never reads and writes in the same cycle.
module t02_ram_bytearray #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [3:0]            wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wr_dat,
  output logic [31:0]           rd_dat
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_be[k]) begin
        mem[addr][8*k +: 8] <= wr_dat[8*k +: 8];
      end
    end
  end

  // The read register holds the last completed read and clears on reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_dat <= '0;
    end else if (rd_en) begin
      rd_dat <= mem[addr];
    end
  end

endmodule

// File: rtl/t02_ram_responder.sv
// RAM-bus responder: captures one read/write, stays busy LATENCY cycles, then commits.
// Latency: busy_o high LATENCY cycles, then one DONE cycle; one access per LATENCY+2 cycles.
// Backpressure: busy_o holds the initiator; requests during BUSY/DONE are ignored.
module t02_ram_responder
  import t02_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = T02_RAM_DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] cpu_data_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] cpu_dat_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  ram_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ram_req_t         req_q;
  logic             capture;
  logic             fire;
  logic             in_range;
  logic             fire_wr;
  logic             fire_rd;
  logic             rd_oor_q;
  logic             err_q;
  logic [3:0]       arr_be;
  logic [31:0]      arr_rdat;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    fire    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (read_i || write_i) begin
          capture = 1'b1;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          fire    = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write wins when both request lines are high.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      req_q <= '0;
    end else if (capture) begin
      req_q.is_write <= write_i;
      req_q.adr      <= adr_i;
      req_q.dat      <= cpu_data_i;
      req_q.sel      <= sel_i;
    end
  end

  assign in_range = addr_in_range(req_q.adr, ADDR_WIDTH);
  assign fire_wr  = fire &&  req_q.is_write && in_range;
  assign fire_rd  = fire && !req_q.is_write && in_range;
  assign arr_be   = fire_wr ? req_q.sel : 4'b0000;

  t02_ram_bytearray #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk    (clk),
    .nrst   (nrst),
    .wr_be  (arr_be),
    .rd_en  (fire_rd),
    .addr   (req_q.adr[ADDR_WIDTH+1:2]),
    .wr_dat (req_q.dat),
    .rd_dat (arr_rdat)
  );

  // An out-of-range read overrides the array word until the next read completes.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_oor_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= fire && !in_range;
      if (fire && !req_q.is_write) begin
        rd_oor_q <= !in_range;
      end
    end
  end

  assign cpu_dat_o = rd_oor_q ? T02_RAM_OOR_READ_VALUE : arr_rdat;
  assign busy_o    = (state_q == ST_BUSY);
  assign err_o     = err_q;

endmodule

// File: tb/tb_t02_ram_responder.sv
// Directed bench for t02_ram_responder: driver pushes hand-computed results into a scoreboard,
// a negedge monitor pops one entry per completed access (busy_o falling edge).
module tb_t02_ram_responder;

  logic        clk = 1'b0;
  logic        nrst;
  logic        read_i;
  logic        write_i;
  logic [31:0] adr_i;
  logic [31:0] cpu_data_i;
  logic [3:0]  sel_i;
  logic [31:0] cpu_dat_o;
  logic        busy_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] dat;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb[$];

  logic prev_busy = 1'b0;
  int   busy_len  = 0;
  logic err_chk   = 1'b0;

  t02_ram_responder #(
    .ADDR_WIDTH(10),
    .LATENCY   (2)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .read_i     (read_i),
    .write_i    (write_i),
    .adr_i      (adr_i),
    .cpu_data_i (cpu_data_i),
    .sel_i      (sel_i),
    .cpu_dat_o  (cpu_dat_o),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: the DONE cycle is the first non-busy cycle after a busy run.
  always @(negedge clk) begin
    if (!nrst) begin
      prev_busy = 1'b0;
      busy_len  = 0;
      err_chk   = 1'b0;
    end else begin
      if (err_chk) begin
        chk("err_one_cycle", {31'd0, err_o}, 32'd0);
        err_chk = 1'b0;
      end
      if (busy_o) begin
        busy_len++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_access: got dat %h err %b expected no access", cpu_dat_o, err_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_dat"}, cpu_dat_o, e.dat);
          chk({e.name, "_err"}, {31'd0, err_o}, {31'd0, e.err});
          chk({e.name, "_busy_len"}, 32'(busy_len), 32'd2);
        end
        busy_len = 0;
        err_chk  = 1'b1;
      end
      prev_busy = busy_o;
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input logic [31:0] exp_dat, input logic exp_err, input string name);
    int n;
    @(negedge clk);
    read_i = rd; write_i = wr; adr_i = adr; cpu_data_i = dat; sel_i = sel;
    sb.push_back('{dat: exp_dat, err: exp_err, name: name});
    @(negedge clk);
    chk({name, "_busy_start"}, {31'd0, busy_o}, 32'd1);
    // Scramble inputs during BUSY; they must not affect the captured access.
    read_i = 1'b0; write_i = 1'b0; adr_i = ~adr; cpu_data_i = ~dat; sel_i = ~sel;
    n = 0;
    while (busy_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got busy_o=1 after %0d cycles required 0", name, n);
    end
    @(negedge clk);
  endtask

  initial begin
    nrst = 1'b0; read_i = 1'b0; write_i = 1'b0;
    adr_i = '0; cpu_data_i = '0; sel_i = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_err",  {31'd0, err_o},  32'd0);
    chk("rst_dat",  cpu_dat_o, 32'h0);
    nrst = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", {31'd0, busy_o}, 32'd0);
    chk("idle_err",  {31'd0, err_o},  32'd0);
    chk("idle_dat",  cpu_dat_o, 32'h0);

    access(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 0, "wr10");
    access(1, 0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 0, "rd10");
    repeat (3) @(negedge clk);
    chk("rd10_held", cpu_dat_o, 32'hDEAD_BEEF);

    access(0, 1, 32'h0000_0010, 32'h1122_3344, 4'b0101, 32'hDEAD_BEEF, 0, "wr10_lanes");
    access(1, 0, 32'h0000_0010, 32'h0,         4'h0,    32'hDE22_BE44, 0, "rd10_lanes");

    access(1, 1, 32'h0000_0020, 32'hA5A5_A5A5, 4'hF, 32'hDE22_BE44, 0, "rdwr20");
    access(1, 0, 32'h0000_0020, 32'h0,         4'h0, 32'hA5A5_A5A5, 0, "rd20");
    access(0, 1, 32'h0000_0020, 32'h0000_0000, 4'h0, 32'hA5A5_A5A5, 0, "wr20_nosel");
    access(1, 0, 32'h0000_0023, 32'h0,         4'hF, 32'hA5A5_A5A5, 0, "rd23");

    access(0, 1, 32'h0000_0000, 32'h0BAD_F00D, 4'hF, 32'hA5A5_A5A5, 0, "wr0");
    access(0, 1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 32'hA5A5_A5A5, 1, "wr_oor");
    access(1, 0, 32'h0000_0000, 32'h0,         4'h0, 32'h0BAD_F00D, 0, "rd0");
    access(1, 0, 32'h0000_1000, 32'h0,         4'h0, 32'h0000_0000, 1, "rd_oor");
    access(0, 1, 32'h0000_0FFC, 32'h55AA_1234, 4'hF, 32'h0000_0000, 0, "wr_top");
    access(1, 0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h55AA_1234, 0, "rd_top");
    access(1, 0, 32'h8000_0010, 32'h0,         4'h0, 32'h0000_0000, 1, "rd_oor_msb");

    // Held read: one DONE cycle, one IDLE cycle, then exactly one new access.
    @(negedge clk);
    read_i = 1'b1; adr_i = 32'h0000_0020; sel_i = 4'h0;
    sb.push_back('{dat: 32'hA5A5_A5A5, err: 1'b0, name: "held_a"});
    sb.push_back('{dat: 32'hA5A5_A5A5, err: 1'b0, name: "held_b"});
    @(negedge clk);
    chk("held_busy", {31'd0, busy_o}, 32'd1);
    repeat (2) @(negedge clk);
    chk("held_done", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    chk("held_idle", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    chk("held_restart", {31'd0, busy_o}, 32'd1);
    read_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_single", {31'd0, busy_o}, 32'd0);
    repeat (2) @(negedge clk);
    chk("held_no_third", {31'd0, busy_o}, 32'd0);

    // Reset during BUSY aborts the write.
    access(0, 1, 32'h0000_0030, 32'hCAFE_0001, 4'hF, 32'hA5A5_A5A5, 0, "wr30");
    @(negedge clk);
    write_i = 1'b1; adr_i = 32'h0000_0030; cpu_data_i = 32'h1234_5678; sel_i = 4'hF;
    @(negedge clk);
    chk("abort_busy_pre", {31'd0, busy_o}, 32'd1);
    write_i = 1'b0;
    #2 nrst = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_dat",  cpu_dat_o, 32'h0);
    chk("abort_err",  {31'd0, err_o}, 32'd0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    access(1, 0, 32'h0000_0030, 32'h0, 4'h0, 32'hCAFE_0001, 0, "rd30");

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
